platform_collision: RTL and testbench

- Consumes the raster stream (x, y, video_on) and the per-pixel platforms_on flag produced by the platform renderer.
- Over one frame, determines whether a W×H sprite at a latched position touches platforms on its bottom, top, left or right edge.
- Presents registered flags plus a one-cycle valid pulse at the end of the visible frame, for use by the sprite motion/jump FSM.

---
 rtl/platform_collision_if.sv | 34 +++
 rtl/platform_collision.sv | 149 ++++++++++++++
 tb/tb_platform_collision.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/platform_collision_if.sv
// Bundle between the raster source, the collision probe block and the sprite
// motion logic: raster samples and sprite position in, registered contact
// flags plus the per-frame report pulse out.
//
// Handshake: there is no back-pressure. A raster sample is consumed when
// p_tick && video_on. coll_valid is a one-clock pulse that marks the cycle in
// which the hit_* flags were refreshed. The flags hold until the next pulse or
// reset.
interface platform_collision_if;
    logic       p_tick;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       platforms_on;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       hit_down;
    logic       hit_up;
    logic       hit_left;
    logic       hit_right;
    logic       coll_valid;
    logic       busy;
    logic [1:0] dbg_state;

    modport master (
        output p_tick, video_on, x, y, platforms_on, sprite_x, sprite_y,
        input  hit_down, hit_up, hit_left, hit_right, coll_valid, busy, dbg_state
    );

    modport slave (
        input  p_tick, video_on, x, y, platforms_on, sprite_x, sprite_y,
        output hit_down, hit_up, hit_left, hit_right, coll_valid, busy, dbg_state
    );
endinterface

// File: rtl/platform_collision.sv
// Sprite/platform contact detector. During one visible frame it counts platform
// pixels on four one-pixel probe lines hugging the sprite (corners excluded).
// It reports bottom/top/left/right contact at the end of the frame.
module platform_collision #(
    parameter int W        = 16,
    parameter int H        = 16,
    parameter int H_LAST   = 639,
    parameter int V_LAST   = 479,
    parameter int MIN_HITS = 2
) (
    input  logic clk,
    input  logic reset,
    platform_collision_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Probe index order: 0 down, 1 up, 2 left, 3 right.
    localparam logic [10:0] W_P    = 11'(W);
    localparam logic [10:0] H_P    = 11'(H);
    localparam logic [10:0] W_M2   = 11'(W - 2);
    localparam logic [10:0] H_M2   = 11'(H - 2);
    localparam logic [9:0]  X_LAST = 10'(H_LAST);
    localparam logic [9:0]  Y_LAST = 10'(V_LAST);
    localparam logic [4:0]  MIN_C  = 5'(MIN_HITS);

    state_t          state_q, state_d;
    logic [9:0]      sx_q, sx_d;
    logic [9:0]      sy_q, sy_d;
    logic [3:0][4:0] cnt_q, cnt_d;
    logic [3:0]      hit_q, hit_d;

    logic        sample;
    logic        at_origin;
    logic        at_last;
    logic        start;
    logic        scan_px;
    logic        eval;
    logic [9:0]  psx;
    logic [9:0]  psy;
    logic [10:0] x11, y11, sx11, sy11;
    logic        in_xr, in_yr;
    logic [3:0]  match;
    logic [3:0]  inc;

    assign sample    = bus.p_tick & bus.video_on;
    assign at_origin = sample && (bus.x == 10'd0) && (bus.y == 10'd0);
    assign at_last   = sample && (bus.x == X_LAST) && (bus.y == Y_LAST);

    // A frame (re)starts on the origin pixel from IDLE or SCAN; a pending
    // report is never interrupted.
    assign start   = at_origin && (state_q != REPORT);
    assign scan_px = sample && (state_q == SCAN) && !at_origin;
    assign eval    = start || scan_px;

    // The origin pixel is judged against the position being latched with it.
    assign psx  = start ? bus.sprite_x : sx_q;
    assign psy  = start ? bus.sprite_y : sy_q;
    assign x11  = {1'b0, bus.x};
    assign y11  = {1'b0, bus.y};
    assign sx11 = {1'b0, psx};
    assign sy11 = {1'b0, psy};

    // Probe geometry in 11 bits so sx+W or y+1 never wraps around.
    always_comb begin
        in_xr    = (x11 >= sx11 + 11'd1) && (x11 <= sx11 + W_M2);
        in_yr    = (y11 >= sy11 + 11'd1) && (y11 <= sy11 + H_M2);
        match[0] = (y11 == sy11 + H_P) && in_xr;
        match[1] = (y11 + 11'd1 == sy11) && in_xr;
        match[2] = (x11 + 11'd1 == sx11) && in_yr;
        match[3] = (x11 == sx11 + W_P) && in_yr;
        inc      = match & {4{eval & bus.platforms_on}};
    end

    // Next-state, counter and flag update logic.
    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;

        if (start) begin
            sx_d = bus.sprite_x;
            sy_d = bus.sprite_y;
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = {4'd0, inc[i]};
            end
        end else if (scan_px) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = (cnt_q[i] == 5'd31) ? 5'd31 : cnt_q[i] + {4'd0, inc[i]};
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (start) begin
                    state_d = SCAN;
                end else if (scan_px && at_last) begin
                    state_d = REPORT;
                    for (int i = 0; i < 4; i++) begin
                        hit_d[i] = (cnt_d[i] >= MIN_C);
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched position, counters and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sx_q    <= 10'd0;
            sy_q    <= 10'd0;
            cnt_q   <= '0;
            hit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.hit_down   = hit_q[0];
    assign bus.hit_up     = hit_q[1];
    assign bus.hit_left   = hit_q[2];
    assign bus.hit_right  = hit_q[3];
    assign bus.coll_valid = (state_q == REPORT);
    assign bus.busy       = (state_q == SCAN);
    assign bus.dbg_state  = 2'(state_q);

endmodule

// File: tb/tb_platform_collision.sv
// Bench for platform_collision. Each frame is a sparse raster: the origin
// pixel, a window of rows/columns around the sprite, one blanking sample per
// row, then the last visible pixel. Every sample is followed by an idle clock
// with p_tick low and platforms_on high.
module tb_platform_collision;

    logic clk;
    logic reset;

    platform_collision_if bus ();

    platform_collision #(
        .W(16), .H(16), .H_LAST(639), .V_LAST(479), .MIN_HITS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sx;
        int sy;
        int pat;
        bit e_down;
        bit e_up;
        bit e_left;
        bit e_right;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int pat      = 0;
    int chg_y    = -1;
    int chg_x    = 0;
    int stop_y   = -1;

    // count report pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.coll_valid) pulses++;
    end

    // scoreboard
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // platform pattern of the current scenario
    function automatic bit pon_f(input int px, input int py);
        case (pat)
            0: return py >= 464;
            1: return px < 16;
            2: return px > 623;
            3: return (px == 105 && py == 464);
            4: return (py == 464) && (px == 105 || px == 106);
            5: return 1'b1;
            6: return (px == 16 && py == 16);
            7: return (px == 100 && py == 464) || (px == 115 && py == 464) ||
                      (px == 99 && py == 448) || (px == 99 && py == 463) ||
                      (px == 116 && py == 463);
            8: return py < 448;
            default: return 1'b0;
        endcase
    endfunction

    // driver: one sample clock, then one idle clock
    task automatic tick_pixel(input int px, input int py, input bit vo, input bit pv);
        bus.x            = 10'(px);
        bus.y            = 10'(py);
        bus.video_on     = vo;
        bus.platforms_on = pv;
        bus.p_tick       = 1'b1;
        @(posedge clk);
        #1;
        bus.p_tick       = 1'b0;
        bus.platforms_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic scan_window(input int sx, input int sy);
        int x0, x1, y0, y1;
        x0 = (sx - 2 < 0) ? 0 : sx - 2;
        y0 = (sy - 2 < 0) ? 0 : sy - 2;
        x1 = (sx + 17 > 639) ? 639 : sx + 17;
        y1 = (sy + 17 > 479) ? 479 : sy + 17;
        for (int yy = y0; yy <= y1; yy++) begin
            if (yy == stop_y) return;
            if (yy == chg_y) bus.sprite_x = 10'(chg_x);
            for (int xx = x0; xx <= x1; xx++) begin
                if (!((xx == 0 && yy == 0) || (xx == 639 && yy == 479)))
                    tick_pixel(xx, yy, 1'b1, pon_f(xx, yy));
            end
            // blanking sample on the down probe: must never count
            tick_pixel(sx + 5, sy + 16, 1'b0, 1'b1);
        end
    endtask

    task automatic end_frame(input string name, input bit rep,
                             input bit ed, input bit eu, input bit el, input bit er);
        bus.x            = 10'd639;
        bus.y            = 10'd479;
        bus.video_on     = 1'b1;
        bus.platforms_on = pon_f(639, 479);
        bus.p_tick       = 1'b1;
        @(posedge clk);
        #1;
        bus.p_tick = 1'b0;
        check({name, "_coll_valid"}, int'(bus.coll_valid), int'(rep));
        check({name, "_hit_down"},   int'(bus.hit_down),   int'(ed));
        check({name, "_hit_up"},     int'(bus.hit_up),     int'(eu));
        check({name, "_hit_left"},   int'(bus.hit_left),   int'(el));
        check({name, "_hit_right"},  int'(bus.hit_right),  int'(er));
        check({name, "_busy_rep"},   int'(bus.busy),       0);
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, int'(bus.coll_valid), 0);
        check({name, "_state_idle"}, int'(bus.dbg_state),  0);
    endtask

    task automatic run_frame(input string name, input int sx, input int sy, input int p,
                             input bit ed, input bit eu, input bit el, input bit er);
        int p0;
        p0           = pulses;
        pat          = p;
        bus.sprite_x = 10'(sx);
        bus.sprite_y = 10'(sy);
        tick_pixel(0, 0, 1'b1, pon_f(0, 0));
        check({name, "_busy_scan"}, int'(bus.busy), 1);
        scan_window(sx, sy);
        end_frame(name, 1'b1, ed, eu, el, er);
        check({name, "_pulses"}, pulses - p0, 1);
    endtask

    vec_t vecs[9];
    int   p0;

    initial begin
        vecs[0] = '{100, 448, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{ 16, 200, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{608, 200, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{100, 448, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{100, 448, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{  0,   0, 5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{  0,   0, 6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{100, 448, 7, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{100, 448, 8, 1'b0, 1'b1, 1'b0, 1'b0};

        bus.p_tick       = 1'b0;
        bus.video_on     = 1'b0;
        bus.x            = 10'd0;
        bus.y            = 10'd0;
        bus.platforms_on = 1'b0;
        bus.sprite_x     = 10'd0;
        bus.sprite_y     = 10'd0;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hits", int'({bus.hit_down, bus.hit_up, bus.hit_left, bus.hit_right}), 0);
        check("rst_valid", int'(bus.coll_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_state", int'(bus.dbg_state), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // table-driven frames
        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].pat,
                      vecs[i].e_down, vecs[i].e_up, vecs[i].e_left, vecs[i].e_right);
        end

        // missing frame start: no report, flags hold (hit_up from vec8)
        p0           = pulses;
        pat          = 0;
        bus.sprite_x = 10'd100;
        bus.sprite_y = 10'd448;
        scan_window(100, 448);
        check("nostart_busy", int'(bus.busy), 0);
        end_frame("nostart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("nostart_pulses", pulses - p0, 0);

        // position is latched at frame start; mid-frame change ignored
        chg_y = 455;
        chg_x = 300;
        run_frame("latch", 100, 448, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chg_y = -1;
        run_frame("latch_next", 300, 448, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset mid-scan aborts the frame, then a full frame reports
        p0           = pulses;
        pat          = 0;
        bus.sprite_x = 10'd100;
        bus.sprite_y = 10'd448;
        tick_pixel(0, 0, 1'b1, 1'b0);
        stop_y = 455;
        scan_window(100, 448);
        stop_y = -1;
        check("abort_busy_pre", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("abort_hits", int'({bus.hit_down, bus.hit_up, bus.hit_left, bus.hit_right}), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.coll_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pulses", pulses - p0, 0);
        run_frame("after_abort", 100, 448, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // second origin mid-scan restarts with new position and cleared counters
        p0           = pulses;
        pat          = 5;
        bus.sprite_x = 10'd0;
        bus.sprite_y = 10'd0;
        tick_pixel(0, 0, 1'b1, 1'b1);
        stop_y = 10;
        scan_window(0, 0);
        stop_y = -1;
        check("restart_pulses_mid", pulses - p0, 0);
        check("restart_hold_down", int'(bus.hit_down), 1);
        run_frame("restart", 16, 200, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_pulses", pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
